vga_vblank_arbiter: RTL and testbench



---
 rtl/vga_vblank_arbiter_if.sv | 25 ++
 rtl/vga_vblank_arbiter.sv | 112 +++++++++++
 tb/tb_vga_vblank_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vga_vblank_arbiter_if.sv
// Counter, request and timing-output bundle shared by the vblank arbiter and its neighbours.
// The master side drives the counters and the request. The slave side is the arbiter.
interface vga_vblank_arbiter_if #(
  parameter int TOTAL_COLS = 800,
  parameter int TOTAL_ROWS = 525
) ();
  logic [$clog2(TOTAL_COLS)-1:0] i_Col_Count;
  logic [$clog2(TOTAL_ROWS)-1:0] i_Row_Count;
  logic                          i_Req;
  logic                          o_Grant;
  logic                          o_Abort;
  logic                          o_VBlank_Start;
  logic                          o_Active;
  logic [7:0]                    o_Frame_Count;

  modport master (
    output i_Col_Count, i_Row_Count, i_Req,
    input  o_Grant, o_Abort, o_VBlank_Start, o_Active, o_Frame_Count
  );

  modport slave (
    input  i_Col_Count, i_Row_Count, i_Req,
    output o_Grant, o_Abort, o_VBlank_Start, o_Active, o_Frame_Count
  );
endinterface

// File: rtl/vga_vblank_arbiter.sv
// Grants one requester a tear-free update window during vertical blanking, and emits active/vblank/frame timing.
// Every output is registered one cycle after the counters. The requester holds i_Req as a level and drops it to release.
module vga_vblank_arbiter #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int GUARD_ROWS  = 1
) (
  input logic             i_Clk,
  input logic             i_Reset,
  vga_vblank_arbiter_if.slave bus
);
  localparam int COL_W   = $clog2(TOTAL_COLS);
  localparam int ROW_W   = $clog2(TOTAL_ROWS);
  localparam int WIN_END = TOTAL_ROWS - GUARD_ROWS;

  localparam logic [COL_W-1:0] ACT_C = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] ACT_R = ROW_W'(ACTIVE_ROWS);
  localparam logic [ROW_W-1:0] WIN_R = ROW_W'(WIN_END);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_WINDOW,
    ST_GRANTED,
    ST_DONE
  } state_t;

  state_t     state, state_nxt;
  logic       grant_q, grant_nxt;
  logic       abort_q, abort_nxt;
  logic       vbs_q, vbs_nxt;
  logic       active_q, active_nxt;
  logic [7:0] frame_q, frame_nxt;

  logic in_visible_rows, past_window, vblank_entry, frame_start;

  // Range compares rather than equality, so a counter jump never strands the FSM.
  assign in_visible_rows = (bus.i_Row_Count < ACT_R);
  assign past_window     = (bus.i_Row_Count >= WIN_R);
  assign vblank_entry    = (bus.i_Row_Count == ACT_R) && (bus.i_Col_Count == '0);
  assign frame_start     = (bus.i_Row_Count == '0) && (bus.i_Col_Count == '0);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    vbs_nxt    = 1'b0;
    frame_nxt  = frame_q;
    active_nxt = in_visible_rows && (bus.i_Col_Count < ACT_C);
    case (state)
      ST_ACTIVE: begin
        if (vblank_entry) begin
          state_nxt = ST_WINDOW;
          vbs_nxt   = 1'b1;
          frame_nxt = frame_q + 8'd1;
        end
      end
      ST_WINDOW: begin
        if (in_visible_rows) begin
          state_nxt = ST_ACTIVE;
        end else if (past_window) begin
          state_nxt = ST_DONE;
        end else if (bus.i_Req) begin
          state_nxt = ST_GRANTED;
          grant_nxt = 1'b1;
        end
      end
      ST_GRANTED: begin
        // Revocation outranks a simultaneous release so the abort is never lost.
        if (in_visible_rows || past_window) begin
          abort_nxt = 1'b1;
          state_nxt = in_visible_rows ? ST_ACTIVE : ST_DONE;
        end else if (!bus.i_Req) begin
          state_nxt = ST_DONE;
        end else begin
          grant_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        if (frame_start || in_visible_rows) begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= ST_ACTIVE;
      grant_q  <= 1'b0;
      abort_q  <= 1'b0;
      vbs_q    <= 1'b0;
      active_q <= 1'b0;
      frame_q  <= 8'd0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      abort_q  <= abort_nxt;
      vbs_q    <= vbs_nxt;
      active_q <= active_nxt;
      frame_q  <= frame_nxt;
    end
  end

  assign bus.o_Grant        = grant_q;
  assign bus.o_Abort        = abort_q;
  assign bus.o_VBlank_Start = vbs_q;
  assign bus.o_Active       = active_q;
  assign bus.o_Frame_Count  = frame_q;
endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Directed bench for vga_vblank_arbiter on a reduced 10x8 raster (6x5 visible, one guard row).
// Expected values are hand-derived for that geometry: vblank entry at (5,0), window closes at row 7.
module tb_vga_vblank_arbiter;
  localparam int TC = 10;
  localparam int TR = 8;
  localparam int COL_W = $clog2(TC);
  localparam int ROW_W = $clog2(TR);

  logic i_Clk = 1'b0;
  logic i_Reset;
  always #5 i_Clk = ~i_Clk;

  vga_vblank_arbiter_if #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR)) bus ();

  vga_vblank_arbiter #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(6), .ACTIVE_ROWS(5), .GUARD_ROWS(1)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int pos_r = 0;
  int pos_c = 0;
  int cnt_act, cnt_vbs, cnt_g, cnt_ab, overlap;
  int vbs_idx, first_g_idx, ab_idx;
  logic prev_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input int c, input logic req);
    bus.i_Row_Count = ROW_W'(r);
    bus.i_Col_Count = COL_W'(c);
    bus.i_Req       = req;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic clear();
    cnt_act = 0; cnt_vbs = 0; cnt_g = 0; cnt_ab = 0; overlap = 0;
    vbs_idx = -1; first_g_idx = -1; ab_idx = -1; prev_g = 1'b0;
  endtask

  // Present n consecutive raster positions starting at (pos_r,pos_c) and tally the outputs.
  task automatic run(input int n, input logic req);
    for (int i = 0; i < n; i++) begin
      drive(pos_r, pos_c, req);
      tick();
      if (bus.o_Active === 1'b1) cnt_act++;
      if (bus.o_VBlank_Start === 1'b1) begin
        cnt_vbs++;
        vbs_idx = pos_r * TC + pos_c;
      end
      if (bus.o_Grant === 1'b1) begin
        if (cnt_g == 0) first_g_idx = pos_r * TC + pos_c;
        cnt_g++;
      end
      if (bus.o_Abort === 1'b1) begin
        cnt_ab++;
        ab_idx = pos_r * TC + pos_c;
      end
      if ((bus.o_Active === 1'b1) && (bus.o_Grant === 1'b1 || prev_g)) overlap++;
      prev_g = (bus.o_Grant === 1'b1);
      pos_c++;
      if (pos_c == TC) begin
        pos_c = 0;
        pos_r = (pos_r + 1) % TR;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_Reset = 1'b1;
    drive(0, 0, 1'b0);
    tick();
    chk("rst_grant", bus.o_Grant, 0);
    chk("rst_abort", bus.o_Abort, 0);
    chk("rst_vbs", bus.o_VBlank_Start, 0);
    chk("rst_active", bus.o_Active, 0);
    chk("rst_frame", bus.o_Frame_Count, 0);
    i_Reset = 1'b0;

    // One idle frame.
    clear();
    run(80, 1'b0);
    chk("idle_active_cycles", cnt_act, 30);
    chk("idle_vbs_pulses", cnt_vbs, 1);
    chk("idle_vbs_pos", vbs_idx, 50);
    chk("idle_grants", cnt_g, 0);
    chk("idle_aborts", cnt_ab, 0);
    chk("idle_frame", bus.o_Frame_Count, 1);

    // Request mid-window, release, then re-request in the same vblank.
    run(53, 1'b0);
    clear();
    run(1, 1'b1);
    chk("req_grant_on", bus.o_Grant, 1);
    run(6, 1'b1);
    run(1, 1'b0);
    chk("rel_grant_off", bus.o_Grant, 0);
    chk("rel_no_abort", bus.o_Abort, 0);
    run(4, 1'b0);
    run(15, 1'b1);
    chk("rel_grant_cycles", cnt_g, 7);
    chk("rel_aborts", cnt_ab, 0);
    chk("rel_frame", bus.o_Frame_Count, 2);

    // Request held across three frames.
    clear();
    run(240, 1'b1);
    chk("hold_grant_cycles", cnt_g, 57);
    chk("hold_first_grant", first_g_idx, 51);
    chk("hold_aborts", cnt_ab, 3);
    chk("hold_abort_pos", ab_idx, 70);
    chk("hold_overlap", overlap, 0);
    chk("hold_active_cycles", cnt_act, 90);
    chk("hold_frame", bus.o_Frame_Count, 5);

    // Counter resync to (0,0) while granted.
    run(52, 1'b1);
    chk("jump_pre_grant", bus.o_Grant, 1);
    pos_r = 0; pos_c = 0;
    run(1, 1'b1);
    chk("jump_grant_off", bus.o_Grant, 0);
    chk("jump_abort", bus.o_Abort, 1);
    run(1, 1'b1);
    chk("jump_abort_single", bus.o_Abort, 0);
    clear();
    run(48, 1'b1);
    chk("jump_no_early_grant", cnt_g, 0);
    run(2, 1'b1);
    chk("jump_regrant", bus.o_Grant, 1);
    chk("jump_frame", bus.o_Frame_Count, 7);

    // Asynchronous reset while granted at (5,5).
    run(3, 1'b1);
    drive(5, 5, 1'b1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("arst_grant", bus.o_Grant, 0);
    chk("arst_abort", bus.o_Abort, 0);
    chk("arst_frame", bus.o_Frame_Count, 0);
    #1;
    i_Reset = 1'b0;
    clear();
    run(35, 1'b1);
    chk("arst_no_grant", cnt_g, 0);
    chk("arst_no_vbs", cnt_vbs, 0);
    chk("arst_no_abort", cnt_ab, 0);

    // Frame counter wrap.
    clear();
    run(255 * 80, 1'b0);
    chk("wrap_frame_255", bus.o_Frame_Count, 255);
    run(80, 1'b0);
    chk("wrap_frame_0", bus.o_Frame_Count, 0);
    chk("wrap_vbs_pulses", cnt_vbs, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
